// File: rtl/muldiv_ctrl_pkg.sv
// Shared codes for the multiply/divide sequencer: op codes, FSM states and alu ops.
package muldiv_ctrl_pkg;

   localparam logic [1:0] MD_MULTU = 2'b00;
   localparam logic [1:0] MD_MULT  = 2'b01;
   localparam logic [1:0] MD_DIVU  = 2'b10;
   localparam logic [1:0] MD_DIV   = 2'b11;

   typedef enum logic [2:0] {
      MDS_IDLE   = 3'd0,
      MDS_NEG_S  = 3'd1,
      MDS_NEG_T  = 3'd2,
      MDS_ITER   = 3'd3,
      MDS_FIX_LO = 3'd4,
      MDS_FIX_HI = 3'd5,
      MDS_DONE   = 3'd6
   } md_state_e;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_NOR = 4'd5,
      OP_SLT = 4'd6,
      OP_SLL = 4'd7,
      OP_SRL = 4'd8,
      OP_SRA = 4'd9
   } alu_op_e;

   // bit 1 of the op code selects divide, bit 0 selects signed
   function automatic logic md_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic md_is_signed(input logic [1:0] op);
      return op[0];
   endfunction

endpackage

// File: rtl/muldiv_ctrl_alu.sv
// Execute-stage alu, parameterised width; the sequencer uses it at N+1 bits.
module alu
   import muldiv_ctrl_pkg::*;
#(
   parameter int N = 32
) (
   input  alu_op_e        alu_op,
   input  logic [N-1:0]   s,
   input  logic [N-1:0]   t,
   input  logic [4:0]     shamt,
   output logic [N-1:0]   y,
   output logic           zero,
   output logic           overflow
);

   logic [N-1:0] sum;
   logic [N-1:0] diff;

   assign sum  = s + t;
   assign diff = s - t;

   always_comb begin
      y        = '0;
      overflow = 1'b0;
      case (alu_op)
         OP_ADD: begin
            y        = sum;
            overflow = (s[N-1] == t[N-1]) && (sum[N-1] != s[N-1]);
         end
         OP_SUB: begin
            y        = diff;
            overflow = (s[N-1] != t[N-1]) && (diff[N-1] != s[N-1]);
         end
         OP_AND: y = s & t;
         OP_OR:  y = s | t;
         OP_XOR: y = s ^ t;
         OP_NOR: y = ~(s | t);
         OP_SLT: y = {{(N-1){1'b0}}, ($signed(s) < $signed(t))};
         OP_SLL: y = t << shamt;
         OP_SRL: y = t >> shamt;
         OP_SRA: y = $signed(t) >>> shamt;
         default: y = '0;
      endcase
   end

   assign zero = (y == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer: magnitudes, N shift-add / restoring steps, sign fix-up,
// all arithmetic routed through one (N+1)-bit alu.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int N = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [N-1:0]  s,
   input  logic [N-1:0]  t,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  hi,
   output logic [N-1:0]  lo,
   output logic          div_zero
);

   localparam int CW = $clog2(N) + 1;

   md_state_e     state, state_nx;
   logic [N:0]    a, b, acc;
   logic [N-1:0]  q;
   logic [CW-1:0] cnt;
   logic [1:0]    op_r;
   logic          sgn_s, sgn_t, neg_lo, neg_hi;

   alu_op_e       alu_op;
   logic [N:0]    alu_s, alu_t, alu_y;
   logic          alu_zero, alu_ovf;
   logic          unused_alu;

   logic          is_div;
   logic          go_dz;
   logic [N:0]    r_hi;
   logic [N:0]    hi_fix;

   assign is_div     = md_is_div(op_r);
   assign go_dz      = md_is_div(op) && (t == '0);
   assign r_hi       = {acc[N-1:0], q[N-1]};
   assign hi_fix     = neg_hi ? alu_y : acc;
   assign unused_alu = alu_zero ^ alu_ovf;

   alu #(.N(N + 1)) u_alu (
      .alu_op   (alu_op),
      .s        (alu_s),
      .t        (alu_t),
      .shamt    (5'd0),
      .y        (alu_y),
      .zero     (alu_zero),
      .overflow (alu_ovf)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= MDS_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         MDS_IDLE:   if (start) state_nx = go_dz ? MDS_DONE : MDS_NEG_S;
         MDS_NEG_S:  state_nx = MDS_NEG_T;
         MDS_NEG_T:  state_nx = MDS_ITER;
         MDS_ITER:   if (cnt == CW'(1)) state_nx = MDS_FIX_LO;
         MDS_FIX_LO: state_nx = MDS_FIX_HI;
         MDS_FIX_HI: state_nx = MDS_DONE;
         MDS_DONE:   state_nx = MDS_IDLE;
         default:    state_nx = MDS_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != MDS_IDLE);
      done = (state == MDS_DONE);
   end

   // One alu operation per state; the datapath below picks up alu_y.
   always_comb begin
      alu_op = OP_ADD;
      alu_s  = '0;
      alu_t  = '0;
      case (state)
         MDS_NEG_S: begin alu_op = OP_SUB; alu_t = a; end
         MDS_NEG_T: begin alu_op = OP_SUB; alu_t = b; end
         MDS_ITER: begin
            if (is_div) begin alu_op = OP_SUB; alu_s = r_hi; alu_t = b; end
            else        begin alu_op = OP_ADD; alu_s = acc;  alu_t = a; end
         end
         MDS_FIX_LO: begin alu_op = OP_SUB; alu_t = {1'b0, q}; end
         MDS_FIX_HI: begin
            // Low word nonzero means the borrow out of it is absorbed: ones' complement suffices
            if (!is_div && q != '0) begin alu_op = OP_NOR; alu_s = acc; alu_t = acc; end
            else                    begin alu_op = OP_SUB; alu_t = acc; end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         a      <= '0;
         b      <= '0;
         acc    <= '0;
         q      <= '0;
         cnt    <= '0;
         op_r   <= MD_MULTU;
         sgn_s  <= 1'b0;
         sgn_t  <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
      end else begin
         case (state)
            MDS_IDLE: if (start) begin
               a     <= {1'b0, s};
               b     <= {1'b0, t};
               acc   <= '0;
               op_r  <= op;
               sgn_s <= md_is_signed(op) & s[N-1];
               sgn_t <= md_is_signed(op) & t[N-1];
            end
            // Bit N is dropped so the magnitude of the most negative value stays N bits
            MDS_NEG_S: if (sgn_s) a <= {1'b0, alu_y[N-1:0]};
            MDS_NEG_T: begin
               if (sgn_t) b <= {1'b0, alu_y[N-1:0]};
               neg_lo <= sgn_s ^ sgn_t;
               neg_hi <= is_div ? sgn_s : (sgn_s ^ sgn_t);
               q      <= is_div ? a[N-1:0] : (sgn_t ? alu_y[N-1:0] : b[N-1:0]);
               cnt    <= CW'(N);
            end
            MDS_ITER: begin
               cnt <= cnt - 1'b1;
               if (is_div) begin
                  acc <= alu_y[N] ? r_hi : alu_y;
                  q   <= {q[N-2:0], ~alu_y[N]};
               end else if (q[0]) begin
                  acc <= {1'b0, alu_y[N:1]};
                  q   <= {alu_y[0], q[N-1:1]};
               end else begin
                  acc <= {1'b0, acc[N:1]};
                  q   <= {acc[0], q[N-1:1]};
               end
            end
            MDS_FIX_LO: if (neg_lo) q <= alu_y[N-1:0];
            MDS_FIX_HI: acc <= hi_fix;
            default: ;
         endcase
      end
   end

   // Result registers load on the edge into DONE so they are already valid while done is high.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
      end else if (state == MDS_IDLE && start && go_dz) begin
         div_zero <= 1'b1;
      end else if (state == MDS_FIX_HI) begin
         hi       <= hi_fix[N-1:0];
         lo       <= q;
         div_zero <= 1'b0;
      end
   end

endmodule
